// File: rtl/uart_rx_assembler.sv
// Packs received UART bytes into one DATA_WIDTH-bit message; the first byte lands in the MSBs.
// An optional trailing XOR checksum byte is compiled in when UART_ASM_CHECKSUM_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no partial frame; the next byteValid starts a frame
// S_COLLECT | partial frame held; inter-byte timer running
// S_CHECK   | all data bytes held; waiting for checksum byte (checksum build only)

module uart_rx_assembler #(
    parameter int DATA_WIDTH    = 24,
    parameter int CLOCK_RATE    = 100_000,
    parameter int BAUD_RATE     = 9600,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic [DATA_WIDTH-1:0] message,
    output logic                  messageValid,
    input  logic                  messageReady,
    output logic                  overflowErr,
    output logic                  timeoutErr,
    output logic                  checksumErr
);

    localparam int NUM_BYTES      = DATA_WIDTH / 8;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CLOCK_RATE / BAUD_RATE;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW             = $clog2(NUM_BYTES + 1);

    localparam logic [TW-1:0] TIMER_EXPIRE = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST     = CW'(NUM_BYTES);

`ifdef UART_ASM_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT} state_t;
`endif

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt, shifted;
    logic [CW-1:0]         byte_cnt, cnt_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic                  run_timer;
    logic                  done;
    logic [DATA_WIDTH-1:0] done_data;
    logic                  timeout_hit;
`ifdef UART_ASM_CHECKSUM_EN
    logic [7:0]            chk_acc, chk_nxt;
    logic                  cksum_bad;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            byte_cnt  <= '0;
            timer     <= '0;
`ifdef UART_ASM_CHECKSUM_EN
            chk_acc   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            byte_cnt  <= cnt_nxt;
            timer     <= timer_nxt;
`ifdef UART_ASM_CHECKSUM_EN
            chk_acc   <= chk_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        cnt_nxt     = byte_cnt;
        timer_nxt   = timer;
        run_timer   = 1'b0;
        done        = 1'b0;
        done_data   = shift_reg;
        timeout_hit = 1'b0;
`ifdef UART_ASM_CHECKSUM_EN
        chk_nxt     = chk_acc;
        cksum_bad   = 1'b0;
`endif
        shifted      = shift_reg << 8;
        shifted[7:0] = byteIn;

        case (state)
            S_IDLE, S_COLLECT: begin
                // Shift reg, count and checksum are all zero in IDLE, so one path serves both.
                if (byteValid) begin
                    shift_nxt = shifted;
                    cnt_nxt   = byte_cnt + CW'(1);
                    timer_nxt = '0;
                    state_nxt = S_COLLECT;
`ifdef UART_ASM_CHECKSUM_EN
                    chk_nxt   = chk_acc ^ byteIn;
                    if (cnt_nxt == CNT_LAST)
                        state_nxt = S_CHECK;
`else
                    if (cnt_nxt == CNT_LAST) begin
                        done      = 1'b1;
                        done_data = shifted;
                        shift_nxt = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_IDLE;
                    end
`endif
                end else if (state == S_COLLECT) begin
                    run_timer = 1'b1;
                end
            end
`ifdef UART_ASM_CHECKSUM_EN
            S_CHECK: begin
                if (byteValid) begin
                    if (byteIn == chk_acc) begin
                        done      = 1'b1;
                        done_data = shift_reg;
                    end else begin
                        cksum_bad = 1'b1;
                    end
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    chk_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    run_timer = 1'b1;
                end
            end
`endif
            default: begin
                shift_nxt = '0;
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase

        if (run_timer) begin
            if (timer == TIMER_EXPIRE) begin
                timeout_hit = 1'b1;
                shift_nxt   = '0;
                cnt_nxt     = '0;
                state_nxt   = S_IDLE;
`ifdef UART_ASM_CHECKSUM_EN
                chk_nxt     = '0;
`endif
            end else if (timer != TIMER_MAX) begin
                timer_nxt = timer + TW'(1);
            end
        end

        if (state_nxt == S_IDLE)
            timer_nxt = '0;
    end

    // Output holding register: a completion only loads when the slot is free or draining this edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            message      <= '0;
            messageValid <= 1'b0;
            overflowErr  <= 1'b0;
            timeoutErr   <= 1'b0;
        end else begin
            overflowErr <= 1'b0;
            timeoutErr  <= timeout_hit;
            if (done && (!messageValid || messageReady)) begin
                message      <= done_data;
                messageValid <= 1'b1;
            end else begin
                if (done)
                    overflowErr <= 1'b1;
                if (messageValid && messageReady)
                    messageValid <= 1'b0;
            end
        end
    end

`ifdef UART_ASM_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            checksumErr <= 1'b0;
        else
            checksumErr <= cksum_bad;
    end
`else
    assign checksumErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_assembler.sv
// Scoreboard bench for uart_rx_assembler: frame-level byte model feeds an expected-message queue,
// a negedge monitor pops on every accepted message and tallies error pulses.

module tb_uart_rx_assembler;

    localparam int DW = 24;
    localparam int NB = DW / 8;
    localparam int TO = 4 * 10 * 100_000 / 9600;
`ifdef UART_ASM_CHECKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic [7:0]    byteIn;
    logic          byteValid;
    logic [DW-1:0] message;
    logic          messageValid;
    logic          messageReady;
    logic          overflowErr;
    logic          timeoutErr;
    logic          checksumErr;

    uart_rx_assembler #(
        .DATA_WIDTH(DW), .CLOCK_RATE(100_000), .BAUD_RATE(9600), .TIMEOUT_BYTES(4)
    ) dut (
        .clk(clk), .resetN(resetN), .byteIn(byteIn), .byteValid(byteValid),
        .message(message), .messageValid(messageValid), .messageReady(messageReady),
        .overflowErr(overflowErr), .timeoutErr(timeoutErr), .checksumErr(checksumErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [7:0]    part[$];
    logic          out_full = 1'b0;
    int exp_to = 0, exp_ov = 0, exp_ck = 0;
    int got_to = 0, got_ov = 0, got_ck = 0;
    logic [DW-1:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is FL bytes with no idle gap of TO cycles or more inside it.
    function automatic void model_idle(input int g);
        if (part.size() > 0 && g >= TO) begin
            exp_to++;
            part.delete();
        end
    endfunction

    function automatic void model_emit(input logic [DW-1:0] m);
        if (out_full && !messageReady) begin
            exp_ov++;
        end else begin
            exp_q.push_back(m);
            out_full = !messageReady;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [DW-1:0] m;
        logic [7:0]    x;
        part.push_back(b);
        if (part.size() == FL) begin
            m = '0;
            x = '0;
            for (int i = 0; i < NB; i++) begin
                m = m * 256 + DW'(part[i]);
                x = x ^ part[i];
            end
`ifdef UART_ASM_CHECKSUM_EN
            if (part[NB] == x) model_emit(m);
            else exp_ck++;
`else
            model_emit(m);
`endif
            part.delete();
        end
    endfunction

    task automatic send(input logic [7:0] b);
        model_byte(b);
        byteIn    = b;
        byteValid = 1'b1;
        @(posedge clk); #1;
        byteValid = 1'b0;
        byteIn    = 8'($urandom);
    endtask

    task automatic idle(input int n);
        model_idle(n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_ready(input logic r);
        messageReady = r;
        if (r) out_full = 1'b0;
    endtask

    // Sends a 3-byte frame (plus its correct checksum when enabled); last_rdy applies on the final byte.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input int last_rdy);
        send(a);
        send(b);
`ifdef UART_ASM_CHECKSUM_EN
        send(c);
        if (last_rdy >= 0) messageReady = last_rdy[0];
        send(a ^ b ^ c);
`else
        if (last_rdy >= 0) messageReady = last_rdy[0];
        send(c);
`endif
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            if (timeoutErr)  got_to++;
            if (overflowErr) got_ov++;
            if (checksumErr) got_ck++;
            if (messageValid && messageReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_message actual=%0h expected=none", message);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("message", message, mon_exp);
                end
            end
        end
    end

    initial begin
        int first;
        int g;
        resetN       = 1'b0;
        byteValid    = 1'b0;
        byteIn       = 8'h00;
        messageReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        check("reset_message", message, 0);
        check("reset_valid", messageValid, 0);
        check("reset_overflow", overflowErr, 0);
        check("reset_timeout", timeoutErr, 0);
        check("reset_checksum", checksumErr, 0);
        @(posedge clk); #1;

        // Bytes spaced one character time; valid one clock after the last byte.
        send(8'h11); idle(103);
        send(8'h22); idle(103);
`ifdef UART_ASM_CHECKSUM_EN
        send(8'h44); idle(103);
        send(8'h77);
`else
        send(8'h44);
`endif
        @(negedge clk);
        check("t1_valid_latency", messageValid, 1);
        check("t1_message", message, 24'h112244);
        @(posedge clk); #1;

        // Stalled partial frame: timeout pulse exactly TO cycles after the last byte.
        send(8'h11);
        send(8'h22);
        model_idle(500);
        first = 0;
        for (int k = 1; k <= 500; k++) begin
            @(posedge clk); #1;
            if (timeoutErr && first == 0) first = k;
        end
        check("t2_timeout_latency", first, TO);
        check("t2_no_valid", messageValid, 0);
        send_frame(8'hAA, 8'hBB, 8'hCC, -1);
        idle(2);
        check("t2_timeout_count", got_to, exp_to);

        // Output held: second completion is dropped with an overflow pulse.
        set_ready(1'b0);
        send_frame(8'h01, 8'h02, 8'h03, -1);
        idle(2);
        send_frame(8'h04, 8'h05, 8'h06, -1);
        idle(2);
        @(negedge clk);
        check("t3_held_message", message, 24'h010203);
        check("t3_held_valid", messageValid, 1);
        check("t3_overflow_count", got_ov, exp_ov);
        @(posedge clk); #1;
        set_ready(1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_valid_drop", messageValid, 0);
        @(posedge clk); #1;

        // Accept and new load on the same edge: no overflow, valid stays high.
        set_ready(1'b0);
        send_frame(8'h0A, 8'h0B, 8'h0C, -1);
        idle(2);
        send_frame(8'h07, 8'h08, 8'h09, 1);
        @(negedge clk);
        check("t4_valid", messageValid, 1);
        check("t4_message", message, 24'h070809);
        @(posedge clk); #1;
        set_ready(1'b1);
        idle(2);
        check("t4_overflow_count", got_ov, exp_ov);

        // Reset mid-frame drops partial data silently.
        send(8'h01);
        send(8'h02);
        resetN = 1'b0;
        part.delete();
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h33, 8'h55, 8'h77, -1);
        idle(3);
        check("t5_timeout_count", got_to, exp_to);
        check("t5_overflow_count", got_ov, exp_ov);

`ifdef UART_ASM_CHECKSUM_EN
        send(8'h11); send(8'h22); send(8'h44); send(8'h77);
        idle(3);
        send(8'h11); send(8'h22); send(8'h44); send(8'h00);
        idle(3);
        check("t6_checksum_count", got_ck, exp_ck);
`endif

        // Random bytes and gaps, including gaps straddling the timeout boundary.
        set_ready(1'b1);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: g = TO - 2;
                    1: g = TO - 1;
                    2: g = TO;
                    default: g = TO + 3;
                endcase
            end else begin
                g = $urandom_range(0, 12);
            end
            idle(g);
            send(8'($urandom));
        end
        idle(TO + 10);

        first = 0;
        while (exp_q.size() != 0 && first < 20) begin
            @(posedge clk); #1;
            first++;
        end
        check("final_queue_empty", exp_q.size(), 0);
        check("final_timeout_count", got_to, exp_to);
        check("final_overflow_count", got_ov, exp_ov);
        check("final_checksum_count", got_ck, exp_ck);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
